bldcm_off_delay: RTL
====================

Name: bldcm_off_delay

Overview:
- Turn-off delay (hold-extension) block for the BLDC gate-drive path; it is the complement of the existing turn-on delay.
- A rising edge on iSig passes to oSig with zero latency.
- A falling edge on iSig is held off: oSig stays high for a runtime-programmable number of clock cycles after iSig drops.
- Used for gate-release stretching and for glitch bridging on feedback lines. Supports retrigger and an immediate forced-off override.

Parameters:
- pWidthDelay, 16, width of the iDelay port; the maximum hold is 2^pWidthDelay-1 cycles.

Ports:
- iClock  input  1  system clock; all state updates on its rising edge.
- iReset  input  1  synchronous, active-high reset.
- iDelay  input  pWidthDelay  hold length D in clock cycles; sampled only in the first cycle in which iSig is seen low after being high.
- iForceOff  input  1  synchronous override; forces the output low and cancels any hold.
- iSig  input  1  signal to be off-delayed.
- oSig  output  1  off-delayed signal.
- oHolding  output  1  high while oSig is high only because of the hold (oSig & ~iSig).

Behaviour:
- States: OFF, ON, HOLD. Internal down-counter rCnt, pWidthDelay bits wide.
- Reset (iReset=1 at a clock edge):
  - The next state is OFF and rCnt=0.
  - oSig and oHolding are combinationally forced to 0 in every cycle in which iReset=1. This applies even if the registered state is still HOLD.
  - A reset in the middle of a hold terminates the hold; no residual pulse appears after reset is released.
- iForceOff=1 (with iReset=0):
  - oSig=0 and oHolding=0 combinationally.
  - The next state is OFF and rCnt=0, regardless of iSig.
  - iForceOff has priority over every transition below.
- Output equation (with iReset=0 and iForceOff=0): oSig = iSig | (state==ON & iDelay!=0) | (state==HOLD).
- OFF:
  - iSig=1 -> ON. oSig=1 in the same cycle, combinationally (zero turn-on latency).
  - iSig=0 -> stay in OFF.
- ON:
  - iSig=1 -> stay in ON.
  - iSig=0 (falling cycle k): D=iDelay is sampled.
    - D=0 -> OFF; oSig=0 at cycle k, so the block is transparent.
    - D=1 -> OFF; oSig=1 at cycle k only.
    - D>=2 -> HOLD; rCnt loaded with D-1.
- HOLD (oSig=1):
  - iSig=1 -> ON (retrigger). There is no low glitch, and the remaining count is discarded.
  - Else, if rCnt==1 -> OFF (the current cycle is the last high cycle).
  - Else rCnt decrements.
- Net timing: if k is the first cycle with iSig=0 and iSig stays low, oSig is high for cycles k..k+D-1 and low from cycle k+D onward. The output is exactly D cycles longer than the input.
- iDelay changes are ignored outside the sampling cycle; a hold in progress keeps its captured length.
- Counter never wraps: D=2^pWidthDelay-1 is the maximum hold, and the counter only decrements from D-1 down to 1.
- Unused state encodings recover to OFF on the next clock.
- Repeated input pulses shorter than D keep oSig continuously high. Every falling edge restarts the hold with the current iDelay.

Test Plan:
- iDelay=5; iSig high for 10 cycles, then low at cycle k -> oSig rises in the same cycle as iSig, stays high through k+4, and is low at k+5; oHolding is high for cycles k..k+4.
- iDelay=0, then iDelay=1 -> with 0, oSig equals iSig on every cycle; with 1, oSig falls exactly one cycle after iSig.
- iDelay=8; iSig low at k, high again at k+3, low again at k+6 -> oSig is continuously high from the first rise through k+13, then low.
- iDelay=20; iSig falls at k; iReset pulsed for 1 cycle at k+4 -> oSig=0 at k+4 and stays 0 afterwards. Repeat with iForceOff in place of iReset; same result. iForceOff=1 while iSig=1 -> oSig=0.
- pWidthDelay=4, iDelay=15 -> oSig high exactly 15 cycles after the fall, with no wrap. iDelay changed from 15 to 2 at k+1 -> the hold is still 15 cycles.
- Randomized iSig/iDelay/iForceOff stream checked against a reference model of the output equation and hold timing -> zero mismatches over 100k cycles.

Source files
------------

// File: rtl/bldcm_off_delay_if.sv
// Signal bundle for the BLDC turn-off delay block: control inputs plus the
// off-delayed output and its hold flag.
interface bldcm_off_delay_if #(
    parameter int pWidthDelay = 16
);
    logic [pWidthDelay-1:0] iDelay;
    logic                   iForceOff;
    logic                   iSig;
    logic                   oSig;
    logic                   oHolding;

    modport master (
        output iDelay,
        output iForceOff,
        output iSig,
        input  oSig,
        input  oHolding
    );

    modport slave (
        input  iDelay,
        input  iForceOff,
        input  iSig,
        output oSig,
        output oHolding
    );
endinterface

// File: rtl/bldcm_off_delay.sv
// Turn-off delay: rising edges pass through with zero latency, falling edges
// are stretched by a runtime-programmable number of clock cycles.
module bldcm_off_delay #(
    parameter int pWidthDelay = 16
) (
    input  logic                iClock,
    input  logic                iReset,
    bldcm_off_delay_if.slave    bus
);
    typedef enum logic [1:0] {
        OFF  = 2'b00,
        ON   = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t                 rState;
    logic [pWidthDelay-1:0] rCnt;

    always_ff @(posedge iClock) begin
        if (iReset || bus.iForceOff) begin
            rState <= OFF;
            rCnt   <= '0;
        end else begin
            case (rState)
                OFF: begin
                    if (bus.iSig) rState <= ON;
                end
                ON: begin
                    if (!bus.iSig) begin
                        // Delay is captured only here; D of 0 or 1 needs no counter.
                        if (bus.iDelay >= pWidthDelay'(2)) begin
                            rState <= HOLD;
                            rCnt   <= bus.iDelay - pWidthDelay'(1);
                        end else begin
                            rState <= OFF;
                        end
                    end
                end
                HOLD: begin
                    if (bus.iSig) begin
                        rState <= ON;
                        rCnt   <= '0;
                    end else if (rCnt == pWidthDelay'(1)) begin
                        rState <= OFF;
                        rCnt   <= '0;
                    end else begin
                        rCnt <= rCnt - pWidthDelay'(1);
                    end
                end
                default: begin
                    rState <= OFF;
                    rCnt   <= '0;
                end
            endcase
        end
    end

    logic sigOut;

    // Outputs stay combinational so the rising edge and the overrides act in the same cycle.
    always_comb begin
        sigOut = 1'b0;
        if (!iReset && !bus.iForceOff) begin
            sigOut = bus.iSig
                   | ((rState == ON) && (bus.iDelay != '0))
                   | (rState == HOLD);
        end
    end

    assign bus.oSig     = sigOut;
    assign bus.oHolding = sigOut & ~bus.iSig;
endmodule
